fifo_rr_arbiter: RTL
====================

Name: fifo_rr_arbiter

Overview:
- Controller that drains NUM_FIFOS input FIFOs into one shared output FIFO.
- Uses round-robin arbitration, with one pop per cycle.
- Programs almost-full/almost-empty thresholds into the FIFOs through an init handshake.
- Tracks a global RESET/INIT/IDLE/ACTIVE/ERROR state and sits between the per-lane FIFOs and the egress FIFO.

Parameters:
- BITNUMBER, 8, data word width.
- NUM_FIFOS, 4, number of input FIFOs (power of 2, at least 2).
- LENGTH, 8, FIFO depth; sets the threshold width TW = clog2(LENGTH)+1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- init  in  1  level request to (re)load thresholds.
- thr_high_in  in  TW  almost-full threshold to load.
- thr_low_in  in  TW  almost-empty threshold to load.
- fifo_empty  in  NUM_FIFOS  per-input-FIFO empty flag.
- fifo_error  in  NUM_FIFOS  per-FIFO overflow/underflow flag.
- fifo_data_out  in  NUM_FIFOS*BITNUMBER  flattened input-FIFO read data; lane i is bits [i*BITNUMBER +: BITNUMBER].
- out_almost_full  in  1  egress FIFO almost-full.
- fifo_rd  out  NUM_FIFOS  one-hot pop to the input FIFOs.
- out_wr  out  1  egress write strobe.
- out_data  out  BITNUMBER  egress write data.
- thr_high  out  TW  registered threshold to the FIFOs.
- thr_low  out  TW  registered threshold to the FIFOs.
- state  out  5  one-hot state.
- idle  out  1  high in IDLE.
- error_out  out  1  high in ERROR.

Behaviour:
- One clock. Reset is synchronous and active-high; clock port is clk and reset port is reset.
- Reset values:
  - state = RESET (5'b00001).
  - fifo_rd, out_wr and out_data = 0.
  - thr_high = LENGTH-1, thr_low = 1.
  - rr_ptr = NUM_FIFOS-1, so lane 0 is granted first.
  - idle = 0, error_out = 0.
- State machine (one-hot: RESET=1, INIT=2, IDLE=4, ACTIVE=8, ERROR=16):
  - RESET -> INIT on the first cycle with reset low.
  - INIT: while init=1, thr_high/thr_low are loaded from the inputs every cycle. INIT -> IDLE when init=0.
  - IDLE: all fifo_empty bits are 1. IDLE -> ACTIVE when any lane is non-empty. IDLE -> INIT when init=1.
  - ACTIVE -> IDLE when all lanes are empty and no read is in flight.
  - ERROR is entered from INIT, IDLE or ACTIVE when |fifo_error=1. Error has priority over every other transition.
  - ERROR is sticky: exit only via reset. In ERROR, fifo_rd and out_wr are forced to 0.
- Arbitration (ACTIVE only, out_almost_full=0):
  - Grant the first non-empty lane strictly after rr_ptr, searching cyclically.
  - Assert fifo_rd for that lane for one cycle and set rr_ptr to the granted lane.
  - At most one grant per cycle.
  - A single non-empty lane may be granted on consecutive cycles.
- Read latency:
  - Input FIFO data is valid the cycle after fifo_rd.
  - The granted lane index is registered, so out_wr=1 and out_data=lane data appear exactly one cycle after fifo_rd.
  - Total arbitration-to-write latency is 1 cycle.
- Back-pressure:
  - out_almost_full=1 blocks new grants in that cycle.
  - The in-flight write from the previous grant still completes. Egress almost-full must therefore leave at least 1 free slot.
- A lane whose fifo_empty rises in the same cycle as its grant is not granted; the grant decision uses the current-cycle flag.
- reset asserted mid-transfer: the pending out_wr is dropped and all outputs return to reset values on the next edge.
- init asserted in ACTIVE is ignored until the block returns to IDLE.

Optional Feature:
- Macro: STRICT_PRIO_EN.
- Defined: fixed priority, lowest non-empty index wins; rr_ptr is not implemented.
- Undefined: round-robin as above.
- Latency, back-pressure and error behaviour are identical in both builds.

Decomposition:
- Package fifo_arb_pkg holds:
  - state encodings ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE, ST_ERROR.
  - TW computation function.
  - Default threshold constants.
- One sub-module: rr_grant. It is combinational: request vector plus pointer in, one-hot grant out; under STRICT_PRIO_EN it is a priority encoder.
- The FSM, threshold registers and data pipeline live in the top.

Test Plan:
- Threshold load: reset 2 cycles, init=1 with thr_high_in=6, thr_low_in=2 for 2 cycles, then init=0 -> thr_high=6, thr_low=2, state INIT->IDLE, idle=1.
- Round-robin: lanes 0-3 each hold 2 words (0xA0,0xA1 / 0xB0,0xB1 / ...) -> out_data sequence A0,B0,C0,D0,A1,B1,C1,D1 with out_wr high 8 consecutive cycles, each 1 cycle after its fifo_rd; then ACTIVE->IDLE.
- Back-pressure: out_almost_full=1 for 3 cycles mid-drain -> no fifo_rd during those cycles, only the one in-flight out_wr; order resumes unchanged.
- Single lane: only lane 2 holds 0x1,0x2,0x3 -> fifo_rd=4'b0100 for 3 cycles, out_data 1,2,3.
- Error: assert fifo_error[1] during ACTIVE -> state=ERROR next cycle, fifo_rd=0, out_wr=0, error_out=1, held after fifo_error drops until reset.
- STRICT_PRIO_EN build: lanes 0 and 3 non-empty -> lane 0 drained fully before lane 3 is granted.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared definitions for the FIFO round-robin arbiter slice.
//   - state_t          : one-hot controller state encoding
//   - tw_calc          : threshold width for a given FIFO depth
//   - thr_high_default : almost-full threshold loaded at reset
//   - THR_LOW_DEFAULT  : almost-empty threshold loaded at reset
package fifo_arb_pkg;

  typedef enum logic [4:0] {
    ST_RESET  = 5'b00001,
    ST_INIT   = 5'b00010,
    ST_IDLE   = 5'b00100,
    ST_ACTIVE = 5'b01000,
    ST_ERROR  = 5'b10000
  } state_t;

  localparam int unsigned THR_LOW_DEFAULT = 1;

  function automatic int unsigned tw_calc(input int unsigned length);
    return $clog2(length) + 1;
  endfunction

  function automatic int unsigned thr_high_default(input int unsigned length);
    return length - 1;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// rr_grant: combinational one-hot grant generator.
// Ports:
//   i_req [N-1:0]  request vector (one bit per lane)
//   i_ptr [IW-1:0] last granted lane; search starts strictly after it
//                  (port absent when STRICT_PRIO_EN is defined)
//   o_gnt [N-1:0]  one-hot grant, all zero when no request
// Macro STRICT_PRIO_EN: fixed priority, lowest requesting index wins.
module rr_grant
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  i_req,
`ifndef STRICT_PRIO_EN
  input  logic [IW-1:0] i_ptr,
`endif
  output logic [N-1:0]  o_gnt
);

  logic w_found;
`ifndef STRICT_PRIO_EN
  logic [IW-1:0] w_idx;
`endif

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
`ifdef STRICT_PRIO_EN
    for (int unsigned i = 0; i < N; i++) begin
      if (i_req[i] && !w_found) begin
        o_gnt[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
`else
    w_idx = '0;
    // i runs 1..N so the pointer lane itself is checked last (wraps to 0 offset)
    for (int unsigned i = 1; i <= N; i++) begin
      w_idx = i_ptr + IW'(i);
      if (i_req[w_idx] && !w_found) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: drains NUM_FIFOS input FIFOs into one egress FIFO,
// one pop per cycle, and programs FIFO thresholds through an init handshake.
// Ports:
//   clk, reset (sync, active-high)
//   init, thr_high_in, thr_low_in     threshold load request and values
//   fifo_empty, fifo_error            per-lane status flags
//   fifo_data_out                     flattened lane read data
//   out_almost_full                   egress back-pressure
//   fifo_rd                           one-hot lane pop
//   out_wr, out_data                  egress write (1 cycle after fifo_rd)
//   thr_high, thr_low                 registered thresholds
//   state, idle, error_out            one-hot state and decoded flags
// Macro STRICT_PRIO_EN: fixed-priority grant, no round-robin pointer.
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned BITNUMBER = 8,
  parameter  int unsigned NUM_FIFOS = 4,
  parameter  int unsigned LENGTH    = 8,
  localparam int unsigned TW        = tw_calc(LENGTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           init,
  input  logic [TW-1:0]                  thr_high_in,
  input  logic [TW-1:0]                  thr_low_in,
  input  logic [NUM_FIFOS-1:0]           fifo_empty,
  input  logic [NUM_FIFOS-1:0]           fifo_error,
  input  logic [NUM_FIFOS*BITNUMBER-1:0] fifo_data_out,
  input  logic                           out_almost_full,
  output logic [NUM_FIFOS-1:0]           fifo_rd,
  output logic                           out_wr,
  output logic [BITNUMBER-1:0]           out_data,
  output logic [TW-1:0]                  thr_high,
  output logic [TW-1:0]                  thr_low,
  output logic [4:0]                     state,
  output logic                           idle,
  output logic                           error_out
);

  localparam int unsigned IW = $clog2(NUM_FIFOS);

  state_t               r_state, w_state_nxt;
  logic [TW-1:0]        r_thr_high, r_thr_low;
  logic                 r_rd_valid;
  logic [IW-1:0]        r_rd_lane;
  logic [NUM_FIFOS-1:0] w_req, w_gnt;
  logic [IW-1:0]        w_gnt_lane;
  logic                 w_any_err, w_all_empty, w_grant_en;
  logic [BITNUMBER-1:0] w_lane_data [NUM_FIFOS];

  always_comb begin
    w_any_err   = |fifo_error;
    w_all_empty = &fifo_empty;
    // a lane raising its error blocks grants in the same cycle
    w_grant_en  = (r_state == ST_ACTIVE) && !out_almost_full && !w_any_err;
    w_req       = ~fifo_empty & {NUM_FIFOS{w_grant_en}};
  end

`ifdef STRICT_PRIO_EN
  rr_grant #(.N(NUM_FIFOS), .IW(IW)) u_grant (
    .i_req (w_req),
    .o_gnt (w_gnt)
  );
`else
  logic [IW-1:0] r_rr_ptr;

  always_ff @(posedge clk) begin
    if (reset)       r_rr_ptr <= IW'(NUM_FIFOS - 1);
    else if (|w_gnt) r_rr_ptr <= w_gnt_lane;
  end

  rr_grant #(.N(NUM_FIFOS), .IW(IW)) u_grant (
    .i_req (w_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt)
  );
`endif

  always_comb begin
    w_gnt_lane = '0;
    for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
      if (w_gnt[i]) w_gnt_lane = IW'(i);
      w_lane_data[i] = fifo_data_out[i*BITNUMBER +: BITNUMBER];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RESET:  w_state_nxt = ST_INIT;
      ST_INIT: begin
        if (w_any_err)  w_state_nxt = ST_ERROR;
        else if (!init) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_any_err)         w_state_nxt = ST_ERROR;
        else if (init)         w_state_nxt = ST_INIT;
        else if (!w_all_empty) w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_any_err)                      w_state_nxt = ST_ERROR;
        else if (w_all_empty && !r_rd_valid) w_state_nxt = ST_IDLE;
      end
      ST_ERROR:  w_state_nxt = ST_ERROR;
      default:   w_state_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RESET;
      r_thr_high <= TW'(thr_high_default(LENGTH));
      r_thr_low  <= TW'(THR_LOW_DEFAULT);
      r_rd_valid <= 1'b0;
      r_rd_lane  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT && init) begin
        r_thr_high <= thr_high_in;
        r_thr_low  <= thr_low_in;
      end
      // lane data arrives the cycle after the pop; remember which lane to mux
      r_rd_valid <= |w_gnt;
      if (|w_gnt) r_rd_lane <= w_gnt_lane;
    end
  end

  always_comb begin
    fifo_rd   = w_gnt;
    out_wr    = r_rd_valid && (r_state != ST_ERROR);
    out_data  = out_wr ? w_lane_data[r_rd_lane] : '0;
    thr_high  = r_thr_high;
    thr_low   = r_thr_low;
    state     = r_state;
    idle      = (r_state == ST_IDLE);
    error_out = (r_state == ST_ERROR);
  end

endmodule
